// File: rtl/usb_tx_packet_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : usb_tx_packet_sequencer
// Purpose  : Serialises one full-speed USB transmit packet (SYNC, PID,
//            payload, optional CRC16, EOP) with bit stuffing and NRZI
//            encoding. One line bit is produced per bit_en_TX strobe.
//            The bit-rate generator is enabled for the packet's duration.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            tx_start          - packet request (accepted in IDLE only)
//            tx_pid[3:0]       - PID code, wire byte {~pid, pid}
//            tx_has_data       - payload bytes follow the PID
//            tx_crc_append     - append CRC16 (CRC build only)
//            byte_data/valid/last, byte_ready - payload byte handshake
//            bit_en_TX         - bit strobe in, bit_clk_en - generator enable
//            dp_out, dm_out    - registered line state (J=10, K=01, SE0=00)
//            tx_active         - output-driver enable
//            tx_done, tx_error - end-of-packet / aborted-packet pulses
// Config   : define USB_TX_CRC16_EN to include the CRC16 generator.
// Revision : 1.0 - initial release
// ============================================================================
module usb_tx_packet_sequencer #(
    parameter int MAX_BYTES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [3:0] tx_pid,
    input  logic       tx_has_data,
    input  logic       tx_crc_append,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    input  logic       byte_last,
    output logic       byte_ready,
    input  logic       bit_en_TX,
    output logic       bit_clk_en,
    output logic       dp_out,
    output logic       dm_out,
    output logic       tx_active,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int                 c_CNT_W   = $clog2(MAX_BYTES + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_BYTES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_SYNC    = 3'd1;
    localparam logic [2:0] c_ST_PID     = 3'd2;
    localparam logic [2:0] c_ST_DATA    = 3'd3;
    localparam logic [2:0] c_ST_CRC     = 3'd4;
    localparam logic [2:0] c_ST_EOP_SE0 = 3'd5;
    localparam logic [2:0] c_ST_EOP_J   = 3'd6;

    // SYNC pattern in transmission order 0000_0001, shifted out from bit 0.
    localparam logic [7:0] c_SYNC_BITS = 8'h80;
    localparam logic [2:0] c_STUFF_RUN = 3'd6;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [7:0]         r_shift;
    logic [2:0]         r_bit_cnt;
    logic [2:0]         r_ones;
    logic               r_level;
    logic               r_dp;
    logic               r_dm;
    logic               r_active;
    logic               r_done;
    logic               r_error;
    logic               r_err_pend;
    logic [3:0]         r_pid;
    logic               r_has_data;
    logic               r_hold_full;
    logic [7:0]         r_hold_data;
    logic               r_hold_last;
    logic               r_last_acc;
    logic               r_cur_last;
    logic [c_CNT_W-1:0] r_byte_cnt;

    logic               w_bit_state;
    logic               w_stuff;
    logic               w_byte_end;
    logic               w_byte_avail;
    logic               w_load_byte;
    logic               w_underrun;
    logic               w_xfer;
    logic               w_emit;
    logic               w_next_level;
    logic               w_crc_req;
    logic               w_crc_hi;
    logic [7:0]         w_crc_lo_byte;
    logic [7:0]         w_crc_hi_byte;

    // States that carry stuffable bits; EOP_SE0 is included so a stuff bit
    // owed after the final data/CRC bit still goes out before the SE0.
    assign w_bit_state  = (r_state == c_ST_PID) || (r_state == c_ST_DATA) ||
                          (r_state == c_ST_CRC) || (r_state == c_ST_EOP_SE0);
    assign w_stuff      = w_bit_state && (r_ones == c_STUFF_RUN);
    assign w_byte_end   = !w_stuff && (r_bit_cnt == 3'd7);
    assign w_byte_avail = r_hold_full && (r_byte_cnt != c_MAX_CNT);
    assign w_xfer       = byte_ready && byte_valid;

    // Bit fed to the NRZI encoder: stuff bits are 0, data comes from bit 0.
    assign w_emit       = w_stuff ? 1'b0 : r_shift[0];
    assign w_next_level = w_emit ? r_level : ~r_level;

`ifdef USB_TX_CRC16_EN
    logic        r_crc_req;
    logic        r_crc_hi;
    logic [15:0] r_crc;
    logic [15:0] w_crc_upd;

    // Reflected form of x^16+x^15+x^2+1 so the remainder leaves LSB first.
    assign w_crc_upd = {1'b0, r_crc[15:1]} ^
                       ((r_crc[0] ^ r_shift[0]) ? 16'hA001 : 16'h0000);
    assign w_crc_req = r_crc_req;
    assign w_crc_hi  = r_crc_hi;
    // Leaving DATA the last payload bit has not yet been folded into r_crc.
    assign w_crc_lo_byte = (r_state == c_ST_DATA) ? ~w_crc_upd[7:0] : ~r_crc[7:0];
    assign w_crc_hi_byte = ~r_crc[15:8];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc     <= 16'hFFFF;
            r_crc_req <= 1'b0;
            r_crc_hi  <= 1'b0;
        end else if ((r_state == c_ST_IDLE) && tx_start) begin
            r_crc     <= 16'hFFFF;
            r_crc_req <= tx_crc_append;
            r_crc_hi  <= 1'b0;
        end else if (bit_en_TX && !w_stuff && (r_state == c_ST_DATA)) begin
            r_crc <= w_crc_upd;
        end else if (bit_en_TX && w_byte_end && (r_state == c_ST_CRC)) begin
            r_crc_hi <= 1'b1;
        end
    end
`else
    logic w_unused_crc;
    assign w_unused_crc  = tx_crc_append;
    assign w_crc_req     = 1'b0;
    assign w_crc_hi      = 1'b1;
    assign w_crc_lo_byte = 8'h00;
    assign w_crc_hi_byte = 8'h00;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_load_byte = 1'b0;
        w_underrun  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (tx_start) begin
                    w_state_nxt = c_ST_SYNC;
                end
            end
            c_ST_SYNC: begin
                if (bit_en_TX && (r_bit_cnt == 3'd7)) begin
                    w_state_nxt = c_ST_PID;
                end
            end
            c_ST_PID: begin
                if (bit_en_TX && w_byte_end) begin
                    if (r_has_data) begin
                        if (w_byte_avail) begin
                            w_state_nxt = c_ST_DATA;
                            w_load_byte = 1'b1;
                        end else begin
                            w_state_nxt = c_ST_EOP_SE0;
                            w_underrun  = 1'b1;
                        end
                    end else if (w_crc_req) begin
                        w_state_nxt = c_ST_CRC;
                    end else begin
                        w_state_nxt = c_ST_EOP_SE0;
                    end
                end
            end
            c_ST_DATA: begin
                if (bit_en_TX && w_byte_end) begin
                    if (r_cur_last) begin
                        w_state_nxt = w_crc_req ? c_ST_CRC : c_ST_EOP_SE0;
                    end else if (w_byte_avail) begin
                        w_load_byte = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_EOP_SE0;
                        w_underrun  = 1'b1;
                    end
                end
            end
            c_ST_CRC: begin
                if (bit_en_TX && w_byte_end && w_crc_hi) begin
                    w_state_nxt = c_ST_EOP_SE0;
                end
            end
            c_ST_EOP_SE0: begin
                if (bit_en_TX && !w_stuff && r_bit_cnt[0]) begin
                    w_state_nxt = c_ST_EOP_J;
                end
            end
            c_ST_EOP_J: begin
                if (bit_en_TX) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        byte_ready = ((r_state == c_ST_PID) || (r_state == c_ST_DATA)) &&
                     !r_hold_full && !r_last_acc;
        bit_clk_en = r_active;
        tx_active  = r_active;
        dp_out     = r_dp;
        dm_out     = r_dm;
        tx_done    = r_done;
        tx_error   = r_error;
    end

    // ------------------------------------------------------------------
    // Datapath: shifter, stuffing, NRZI line, holding register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift     <= 8'h00;
            r_bit_cnt   <= 3'd0;
            r_ones      <= 3'd0;
            r_level     <= 1'b1;
            r_dp        <= 1'b1;
            r_dm        <= 1'b0;
            r_active    <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_pend  <= 1'b0;
            r_pid       <= 4'h0;
            r_has_data  <= 1'b0;
            r_hold_full <= 1'b0;
            r_hold_data <= 8'h00;
            r_hold_last <= 1'b0;
            r_last_acc  <= 1'b0;
            r_cur_last  <= 1'b0;
            r_byte_cnt  <= '0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;

            if (w_xfer) begin
                r_hold_full <= 1'b1;
                r_hold_data <= byte_data;
                r_hold_last <= byte_last;
                if (byte_last) begin
                    r_last_acc <= 1'b1;
                end
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (tx_start) begin
                        r_active    <= 1'b1;
                        r_pid       <= tx_pid;
                        r_has_data  <= tx_has_data;
                        r_shift     <= c_SYNC_BITS;
                        r_bit_cnt   <= 3'd0;
                        r_ones      <= 3'd0;
                        r_level     <= 1'b1;
                        r_hold_full <= 1'b0;
                        r_last_acc  <= 1'b0;
                        r_cur_last  <= 1'b0;
                        r_byte_cnt  <= '0;
                        r_err_pend  <= 1'b0;
                    end
                end
                c_ST_SYNC: begin
                    if (bit_en_TX) begin
                        r_level   <= w_next_level;
                        r_dp      <= w_next_level;
                        r_dm      <= ~w_next_level;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        r_ones    <= 3'd0;
                        r_shift   <= (r_bit_cnt == 3'd7) ? {~r_pid, r_pid}
                                                         : {1'b0, r_shift[7:1]};
                    end
                end
                c_ST_PID, c_ST_DATA, c_ST_CRC: begin
                    if (bit_en_TX) begin
                        r_level <= w_next_level;
                        r_dp    <= w_next_level;
                        r_dm    <= ~w_next_level;
                        if (w_stuff) begin
                            r_ones <= 3'd0;
                        end else begin
                            r_ones    <= r_shift[0] ? (r_ones + 3'd1) : 3'd0;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (w_byte_end) begin
                                if (w_load_byte) begin
                                    r_shift     <= r_hold_data;
                                    r_cur_last  <= r_hold_last;
                                    r_hold_full <= 1'b0;
                                    r_byte_cnt  <= r_byte_cnt + c_CNT_ONE;
                                end else if (r_state == c_ST_CRC) begin
                                    r_shift <= w_crc_hi_byte;
                                end else if (w_state_nxt == c_ST_CRC) begin
                                    r_shift <= w_crc_lo_byte;
                                end
                                if (w_underrun) begin
                                    r_err_pend <= 1'b1;
                                end
                            end
                        end
                    end
                end
                c_ST_EOP_SE0: begin
                    if (bit_en_TX) begin
                        r_ones <= 3'd0;
                        if (w_stuff) begin
                            r_level <= w_next_level;
                            r_dp    <= w_next_level;
                            r_dm    <= ~w_next_level;
                        end else begin
                            r_dp      <= 1'b0;
                            r_dm      <= 1'b0;
                            r_level   <= 1'b1;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                c_ST_EOP_J: begin
                    if (bit_en_TX) begin
                        r_dp     <= 1'b1;
                        r_dm     <= 1'b0;
                        r_level  <= 1'b1;
                        r_active <= 1'b0;
                        r_done   <= 1'b1;
                        r_error  <= r_err_pend;
                    end
                end
                default: begin
                    r_active <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_packet_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_tx_packet_sequencer
// Purpose  : Directed, table-driven bench for usb_tx_packet_sequencer.
//            Captures the line state at every strobe, NRZI-decodes and
//            de-stuffs it, and compares against hand-computed packets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_tx_packet_sequencer;

    localparam int MAXB = 4;

    logic       clk;
    logic       rst;
    logic       tx_start;
    logic [3:0] tx_pid;
    logic       tx_has_data;
    logic       tx_crc_append;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_last;
    logic       byte_ready;
    logic       bit_en_TX;
    logic       bit_clk_en;
    logic       dp_out;
    logic       dm_out;
    logic       tx_active;
    logic       tx_done;
    logic       tx_error;

    usb_tx_packet_sequencer #(.MAX_BYTES(MAXB)) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_start     (tx_start),
        .tx_pid       (tx_pid),
        .tx_has_data  (tx_has_data),
        .tx_crc_append(tx_crc_append),
        .byte_data    (byte_data),
        .byte_valid   (byte_valid),
        .byte_last    (byte_last),
        .byte_ready   (byte_ready),
        .bit_en_TX    (bit_en_TX),
        .bit_clk_en   (bit_clk_en),
        .dp_out       (dp_out),
        .dm_out       (dm_out),
        .tx_active    (tx_active),
        .tx_done      (tx_done),
        .tx_error     (tx_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]      pid;
        logic            has_data;
        logic            crc;
        int              n_sup;      // bytes offered upstream
        logic [4:0][7:0] d;          // offered bytes, d[0] first
        int              last_idx;   // index flagged byte_last, -1 none
        int              exp_strobes;
        logic            exp_err;
        int              exp_nb;     // payload/CRC bytes expected on wire
        logic [4:0][7:0] e;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;
    int div    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock with the bit-rate generator model: strobe every 4th cycle.
    task automatic step(output bit stb);
        stb = bit_clk_en && (div == 3);
        div = bit_clk_en ? ((div + 1) % 4) : 0;
        bit_en_TX = stb;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int vi, input bit inject, input bit chk_wire);
        logic [1:0]  ls [0:127];
        logic        dbits [0:255];
        int          ns, nd, idx, ones, stray;
        int          off_moves;
        bit          stb, xfer, done;
        logic        err_at_done;
        logic [1:0]  prev_line, prev;
        logic [7:0]  sync_b, byt;
        logic [37:0] cap;
        logic [37:0] ack_wire;
        ack_wire = 38'b01_10_01_10_01_10_01_01_10_10_01_10_10_01_01_01_00_00_10;

        tx_pid = v.pid; tx_has_data = v.has_data; tx_crc_append = v.crc;
        tx_start = 1'b1; bit_en_TX = 1'b0;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        div = 0;
        chk($sformatf("v%0d_enable_after_start", vi), {bit_clk_en, tx_active}, 2'b11);
        chk($sformatf("v%0d_line_j_after_start", vi), {dp_out, dm_out}, 2'b10);

        ns = 0; idx = 0; done = 1'b0; off_moves = 0; stray = 0; err_at_done = 1'b0;
        prev_line = {dp_out, dm_out};
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            byte_valid = (idx < v.n_sup);
            byte_data  = (idx < 5) ? v.d[idx] : 8'h00;
            byte_last  = (idx == v.last_idx);
            xfer = byte_ready && byte_valid;
            if (inject && cyc == 6) begin
                tx_start = 1'b1;
                tx_pid   = ~v.pid;
            end else begin
                tx_start = 1'b0;
            end
            step(stb);
            if (xfer) idx++;
            if (stb) begin
                if (ns < 128) ls[ns] = {dp_out, dm_out};
                ns++;
            end else if ({dp_out, dm_out} !== prev_line) begin
                off_moves++;
            end
            prev_line = {dp_out, dm_out};
            if (tx_error && !tx_done) stray++;
            if (tx_done) begin
                done = 1'b1;
                err_at_done = tx_error;
                chk($sformatf("v%0d_active_low_at_done", vi), {tx_active, bit_clk_en}, 2'b00);
            end
        end
        tx_start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0; bit_en_TX = 1'b0;

        chk($sformatf("v%0d_done_seen", vi), done, 1'b1);
        chk($sformatf("v%0d_strobes", vi), ns, v.exp_strobes);
        chk($sformatf("v%0d_error", vi), err_at_done, v.exp_err);
        chk($sformatf("v%0d_err_without_done", vi), stray, 0);
        chk($sformatf("v%0d_line_off_strobe", vi), off_moves, 0);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_done_one_cycle", vi), {tx_done, tx_error, tx_active}, 3'b000);

        if (ns >= 11 && ns <= 128) begin
            chk($sformatf("v%0d_eop", vi), {ls[ns-3], ls[ns-2], ls[ns-1]}, 6'b00_00_10);
            prev = 2'b10; nd = 0; ones = 0; sync_b = 8'h00;
            for (int i = 0; i < ns - 3; i++) begin
                logic b;
                b = (ls[i] == prev);
                prev = ls[i];
                if (i < 8) begin
                    sync_b[i] = b;
                end else if (ones == 6) begin
                    ones = 0;
                end else begin
                    dbits[nd] = b;
                    nd++;
                    ones = b ? ones + 1 : 0;
                end
            end
            chk($sformatf("v%0d_sync", vi), sync_b, 8'h80);
            chk($sformatf("v%0d_bitcount", vi), nd, 8 * (1 + v.exp_nb));
            if (nd >= 8 * (1 + v.exp_nb)) begin
                for (int k = 0; k < 8; k++) byt[k] = dbits[k];
                chk($sformatf("v%0d_pid", vi), byt, {~v.pid, v.pid});
                for (int j = 0; j < v.exp_nb; j++) begin
                    for (int k = 0; k < 8; k++) byt[k] = dbits[8 + 8 * j + k];
                    chk($sformatf("v%0d_byte%0d", vi, j), byt, v.e[j]);
                end
            end
            if (chk_wire && ns == 19) begin
                cap = '0;
                for (int i = 0; i < 19; i++) cap = {cap[35:0], ls[i]};
                chk($sformatf("v%0d_ack_wire", vi), cap, ack_wire);
            end
        end else begin
            chk($sformatf("v%0d_capture_length_sane", vi), ns, v.exp_strobes);
        end
    endtask

    vec_t vecs [11];

    initial begin
        bit stb;
        //         pid   hd    crc   n  d                   last  strb err   nb e
        vecs[0]  = '{4'h2, 1'b0, 1'b0, 0, 40'h0,              -1,   19, 1'b0, 0, 40'h0};
        vecs[1]  = '{4'h3, 1'b1, 1'b0, 2, 40'h00_0000_FFFF,    1,   38, 1'b0, 2, 40'h00_0000_FFFF};
        vecs[2]  = '{4'hB, 1'b1, 1'b0, 1, 40'h0,               0,   27, 1'b0, 1, 40'h0};
        vecs[3]  = '{4'h3, 1'b1, 1'b0, 1, 40'h00_0000_00FF,   -1,   28, 1'b1, 1, 40'h00_0000_00FF};
        vecs[4]  = '{4'hB, 1'b1, 1'b0, 1, 40'h00_0000_00FC,   -1,   28, 1'b1, 1, 40'h00_0000_00FC};
        vecs[5]  = '{4'hB, 1'b1, 1'b0, 1, 40'h00_0000_00FC,    0,   28, 1'b0, 1, 40'h00_0000_00FC};
        vecs[6]  = '{4'hB, 1'b1, 1'b0, 5, 40'h05_0403_0201,    4,   51, 1'b1, 4, 40'h00_0403_0201};
        vecs[7]  = '{4'h1, 1'b0, 1'b0, 0, 40'h0,              -1,   19, 1'b0, 0, 40'h0};
        vecs[8]  = '{4'h3, 1'b1, 1'b0, 0, 40'h0,              -1,   19, 1'b1, 0, 40'h0};
`ifdef USB_TX_CRC16_EN
        vecs[9]  = '{4'h3, 1'b0, 1'b1, 0, 40'h0,              -1,   35, 1'b0, 2, 40'h0};
`else
        vecs[9]  = '{4'h3, 1'b0, 1'b1, 0, 40'h0,              -1,   19, 1'b0, 0, 40'h0};
`endif
        vecs[10] = '{4'hB, 1'b1, 1'b0, 3, 40'h00_00FF_3CA5,    2,   44, 1'b0, 3, 40'h00_00FF_3CA5};

        rst = 1'b1; tx_start = 1'b0; tx_pid = 4'h0; tx_has_data = 1'b0; tx_crc_append = 1'b0;
        byte_data = 8'h00; byte_valid = 1'b0; byte_last = 1'b0; bit_en_TX = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_line", {dp_out, dm_out}, 2'b10);
        chk("reset_ctrl", {tx_active, bit_clk_en, byte_ready, tx_done, tx_error}, 5'b00000);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_after_reset", {tx_active, bit_clk_en, dp_out, dm_out}, 4'b0010);

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], i, 1'b0, i == 0);
        end

        // tx_start during SYNC with a different PID must be ignored.
        run_vec(vecs[0], 20, 1'b1, 1'b1);

        // Reset in the middle of DATA: everything back to reset values, no EOP.
        tx_pid = 4'h3; tx_has_data = 1'b1; tx_crc_append = 1'b0; tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0; div = 0;
        byte_valid = 1'b1; byte_data = 8'h55; byte_last = 1'b0;
        repeat (90) step(stb);
        chk("mid_data_active", tx_active, 1'b1);
        rst = 1'b1; bit_en_TX = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_line", {dp_out, dm_out}, 2'b10);
        chk("rst_mid_ctrl", {tx_active, bit_clk_en, byte_ready, tx_done, tx_error}, 5'b00000);
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0; rst = 1'b0; byte_valid = 1'b0;
        chk("start_during_rst_ignored", {tx_active, bit_clk_en}, 2'b00);
        @(posedge clk);
        #1;
        chk("still_idle_after_rst", {tx_active, tx_done, dp_out, dm_out}, 4'b0010);

        // Bus usable again after the abort.
        run_vec(vecs[2], 30, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/usb_tx_packet_sequencer.md
# usb_tx_packet_sequencer

Sequences one full-speed USB transmit packet onto the bus: SYNC, PID, data bytes, optional CRC16, then EOP, with bit stuffing and NRZI encoding. Sits between the TX packet FIFO and the D+/D- output drivers. Gates the TX bit-rate generator (`USB_TX_Output_Clock`) on for the packet's duration and advances one line bit per `bit_en_TX` strobe.

## Interface
- `MAX_BYTES`, default 64: maximum payload bytes per packet; sizes the byte counter.

- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: synchronous, active-high reset.
- `tx_start` in 1: single-cycle request to send a packet; honoured only in IDLE.
- `tx_pid` in 4: PID code; the wire byte is {~tx_pid, tx_pid}.
- `tx_has_data` in 1: packet carries payload bytes after the PID.
- `tx_crc_append` in 1: append CRC16 after the payload (only when `USB_TX_CRC16_EN` is defined).
- `byte_data` in 8: payload byte.
- `byte_valid` in 1: `byte_data` is valid.
- `byte_last` in 1: this byte is the final payload byte.
- `byte_ready` out 1: holding register is empty and accepts a byte.
- `bit_en_TX` in 1: one-cycle bit strobe from the bit-rate generator.
- `bit_clk_en` out 1: run enable to the bit-rate generator.
- `dp_out`, `dm_out` out 1 each: line state (J = 1/0, K = 0/1, SE0 = 0/0).
- `tx_active` out 1: output-driver enable.
- `tx_done` out 1: one-cycle pulse at packet end.
- `tx_error` out 1: one-cycle pulse, coincident with `tx_done`, for an aborted packet.

## Operation
- States: IDLE → SYNC → PID → DATA → CRC → EOP_SE0 → EOP_J → IDLE.
- IDLE:
  - line J, `tx_active`=0.
  - `tx_start` latches `tx_pid`, `tx_has_data` and `tx_crc_append`, then enters SYNC.
- SYNC: 8 bits 0000_0001, LSB first; the wire shows KJKJKJKK.
- PID: 8 bits LSB first. Then:
  - DATA if `tx_has_data`;
  - else CRC if the CRC is enabled and requested;
  - else EOP_SE0.
- DATA:
  - One-entry holding register. `byte_ready` is high in PID/DATA while the register is empty and `byte_last` has not yet been accepted.
  - A transfer occurs when `byte_valid` and `byte_ready` are both high.
  - After the 8th bit of the current byte (plus any pending stuff bit), the next byte loads from the holding register.
  - After the last byte: CRC if enabled and requested, else EOP_SE0.
- Underrun: a byte is needed but the holding register is empty.
  - Go directly to EOP_SE0 and flag an error.
  - `tx_error` pulses together with `tx_done`.
- `MAX_BYTES` limit: the byte counter saturates. A packet exceeding `MAX_BYTES` bytes is treated as an underrun at byte `MAX_BYTES`+1.
- NRZI: a 0 bit toggles the line and a 1 bit holds it. The line level starts at J.
- Bit stuffing:
  - `ones_cnt` (3 bits) counts consecutive 1s across byte and field boundaries, PID through CRC.
  - When `ones_cnt`==6, the next strobe emits a stuffed 0, clears `ones_cnt`, and does not advance the data bit.
  - A stuff bit owed after the final CRC or data bit is sent before EOP.
  - SYNC clears `ones_cnt` at its final bit.
- EOP: SE0 for 2 strobes, then J for 1 strobe. Then `tx_done` pulses, and `tx_active` and `bit_clk_en` fall; return to IDLE.
- `tx_start` outside IDLE is ignored. Byte inputs outside PID/DATA are ignored.

## Timing
- Reset values:
  - `dp_out`=1, `dm_out`=0;
  - `tx_active`=0, `bit_clk_en`=0, `byte_ready`=0, `tx_done`=0, `tx_error`=0;
  - state IDLE.
- `rst` mid-packet: on the next edge, all outputs go to their reset values, with no EOP. While `rst` is high, `tx_start` is ignored.
- `tx_start` sampled at edge N: `bit_clk_en` and `tx_active` are high from N+1. The first SYNC bit appears on the edge after the first `bit_en_TX`.
- All line outputs are registered and change only on an edge where `bit_en_TX`=1.
- Packet length in strobes = 16 + 8·bytes + 16·crc + stuff bits + 3.
- `tx_done` is asserted the cycle after the EOP_J strobe edge. `tx_start` is accepted again on the following cycle.

## Configuration
- `USB_TX_CRC16_EN` defined:
  - CRC16 polynomial x^16+x^15+x^2+1, init 0xFFFF, computed over payload bits LSB first.
  - The complement is sent LSB first when `tx_crc_append`=1.
- Not defined: the CRC state and its logic are absent and `tx_crc_append` is ignored. Upstream supplies any CRC bytes as payload.

## Test plan
- ACK (`tx_pid`=4'h2, no data, no CRC) → SYNC KJKJKJKK, PID 0xD2 LSB first, SE0 SE0 J. `tx_done` after 19 strobes; `tx_error`=0.
- DATA0 (4'h3), payload 0xFF, 0xFF (`byte_last` on the 2nd), CRC off → 3 stuffed 0s (after 1s #6, #12, #18 counting the PID's trailing two) → 38 strobes total.
- ZLP with CRC (`USB_TX_CRC16_EN`, `tx_has_data`=0, `tx_crc_append`=1) → PID, then CRC bytes 0x00 0x00 (line toggles every bit), then EOP.
- Underrun: `byte_valid` held low after the first byte → EOP starts right after byte 1 plus any owed stuff bit; `tx_error` and `tx_done` pulse in the same cycle.
- `rst` pulse during DATA → the next cycle shows `dp_out`=1, `dm_out`=0, `tx_active`=0, `bit_clk_en`=0, `byte_ready`=0.
- `tx_start` during SYNC → ignored: PID unchanged and exactly one `tx_done`.
